uart_bus_master: RTL and testbench

- Serial-to-bus bridge: the initiator end of the peripheral data bus (rd/wr/addr/wdata/rdata), driven by a host over an 8N1 UART link.
- Host sends command frames. The block decodes them and issues single-cycle bus writes or reads. For reads, it returns the 32-bit read data over the serial TX line.
- Used for board bring-up, memory poke/peek and program loading while the CPU is held off the bus.

---
 rtl/uart_bus_master.sv | 273 +++++++++++++++++++++++++++
 tb/tb_uart_bus_master.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_bus_master.sv
// UART-driven bus initiator: 'W' A3..A0 D3..D0 issues one wr, 'R' A3..A0 issues one rd and returns the word MSB first.
// Optional build macro UART_BUS_MASTER_ACK_EN: 0x06 after each write, 0x15 on a framing error inside a partial frame.
`timescale 1ns/1ps
module uart_bus_master #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned TIMEOUT_CYC  = 1000000
) (
    input  logic        CLK,
    input  logic        Reset_n,
    input  logic        in,
    output logic        out,
    output logic        rd,
    output logic        wr,
    output logic [31:0] addr,
    output logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic        busy
);
    localparam int unsigned BIT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] HALF_LAST = BIT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [7:0] CMD_WR = 8'h57;
    localparam logic [7:0] CMD_RD = 8'h52;

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_t;
    typedef enum logic [2:0] {
        P_IDLE, P_ADDR, P_DATA, P_WR, P_RD, P_SEND
`ifdef UART_BUS_MASTER_ACK_EN
        , P_ACK
`endif
    } p_state_t;

`ifdef UART_BUS_MASTER_ACK_EN
    localparam p_state_t WR_NEXT   = P_ACK;
    localparam p_state_t FERR_NEXT = P_ACK;
`else
    localparam p_state_t WR_NEXT   = P_IDLE;
    localparam p_state_t FERR_NEXT = P_IDLE;
`endif

    // ---------------- RX synchronizer and receiver ----------------
    logic rx_meta, rx_sync, rx_prev;

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= in;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    rx_state_t        r_state, r_next;
    logic [BIT_W-1:0] r_cnt;
    logic [2:0]       r_bit;
    logic [7:0]       r_shift;
    logic             r_tick;
    logic             rx_valid, rx_ferr;
    logic [7:0]       rx_byte;

    assign rx_byte = r_shift;

    always_comb begin
        r_next   = r_state;
        rx_valid = 1'b0;
        rx_ferr  = 1'b0;
        r_tick   = (r_state == R_START) ? (r_cnt == HALF_LAST) : (r_cnt == BIT_LAST);
        case (r_state)
            R_IDLE:  if (rx_prev && !rx_sync) r_next = R_START;
            R_START: if (r_tick) r_next = rx_sync ? R_IDLE : R_DATA;
            R_DATA:  if (r_tick && r_bit == 3'd7) r_next = R_STOP;
            R_STOP: begin
                if (r_tick) begin
                    r_next   = R_IDLE;
                    rx_valid = rx_sync;
                    rx_ferr  = !rx_sync;
                end
            end
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= R_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= r_next;
            if (r_state == R_IDLE || r_tick) r_cnt <= '0;
            else                             r_cnt <= r_cnt + 1'b1;
            if (r_state == R_START) r_bit <= '0;
            if (r_state == R_DATA && r_tick) begin
                r_shift <= {rx_sync, r_shift[7:1]};
                r_bit   <= r_bit + 1'b1;
            end
        end
    end

    // ---------------- TX serializer ----------------
    tx_state_t        t_state, t_next;
    logic [BIT_W-1:0] t_cnt;
    logic [2:0]       t_bit;
    logic [7:0]       t_shift;
    logic             t_tick;
    logic             tx_start, tx_done;
    logic [7:0]       tx_byte;

    assign t_tick = (t_cnt == BIT_LAST);

    always_comb begin
        t_next  = t_state;
        tx_done = 1'b0;
        case (t_state)
            T_IDLE:  if (tx_start) t_next = T_START;
            T_START: if (t_tick) t_next = T_DATA;
            T_DATA:  if (t_tick && t_bit == 3'd7) t_next = T_STOP;
            T_STOP: begin
                if (t_tick) begin
                    t_next  = T_IDLE;
                    tx_done = 1'b1;
                end
            end
            default: t_next = T_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            t_state <= T_IDLE;
            t_cnt   <= '0;
            t_bit   <= '0;
            t_shift <= '0;
        end else begin
            t_state <= t_next;
            if (t_state == T_IDLE || t_tick) t_cnt <= '0;
            else                             t_cnt <= t_cnt + 1'b1;
            if (t_state == T_IDLE && tx_start) begin
                t_shift <= tx_byte;
                t_bit   <= '0;
            end
            if (t_state == T_DATA && t_tick) begin
                t_shift <= {1'b0, t_shift[7:1]};
                t_bit   <= t_bit + 1'b1;
            end
        end
    end

    always_comb begin
        case (t_state)
            T_START: out = 1'b0;
            T_DATA:  out = t_shift[0];
            default: out = 1'b1;
        endcase
    end

    // ---------------- Frame parser / bus sequencer ----------------
    p_state_t         p_state, p_next;
    logic [1:0]       p_cnt;
    logic             cmd_rd;
    logic [TMO_W-1:0] tmo_cnt;
    logic [31:0]      rd_word;
    logic [2:0]       send_idx;
    logic             is_cmd;
    logic             tmo_hit;
`ifdef UART_BUS_MASTER_ACK_EN
    logic [7:0]       ack_byte;
`endif

    assign is_cmd  = (rx_byte == CMD_WR) || (rx_byte == CMD_RD);
    assign tmo_hit = (tmo_cnt == TMO_LAST);

    always_comb begin
        p_next   = p_state;
        tx_start = 1'b0;
        tx_byte  = rd_word[31:24];
        case (p_state)
            P_IDLE: if (rx_valid && is_cmd) p_next = P_ADDR;
            // rx_valid is tested before the timeout so a byte arriving on the last cycle still counts
            P_ADDR: begin
                if (rx_valid) begin
                    if (p_cnt == 2'd3) p_next = cmd_rd ? P_RD : P_DATA;
                end else if (rx_ferr) begin
                    p_next = FERR_NEXT;
                end else if (tmo_hit) begin
                    p_next = P_IDLE;
                end
            end
            P_DATA: begin
                if (rx_valid) begin
                    if (p_cnt == 2'd3) p_next = P_WR;
                end else if (rx_ferr) begin
                    p_next = FERR_NEXT;
                end else if (tmo_hit) begin
                    p_next = P_IDLE;
                end
            end
            P_WR: p_next = WR_NEXT;
            P_RD: p_next = P_SEND;
            P_SEND: begin
                tx_start = (t_state == T_IDLE) && !send_idx[2];
                case (send_idx[1:0])
                    2'd0:    tx_byte = rd_word[31:24];
                    2'd1:    tx_byte = rd_word[23:16];
                    2'd2:    tx_byte = rd_word[15:8];
                    default: tx_byte = rd_word[7:0];
                endcase
                if (tx_done && send_idx[2]) p_next = P_IDLE;
            end
`ifdef UART_BUS_MASTER_ACK_EN
            P_ACK: begin
                tx_start = (t_state == T_IDLE) && (send_idx == 3'd0);
                tx_byte  = ack_byte;
                if (tx_done) p_next = P_IDLE;
            end
`endif
            default: p_next = P_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            p_state  <= P_IDLE;
            p_cnt    <= '0;
            cmd_rd   <= 1'b0;
            tmo_cnt  <= '0;
            rd_word  <= '0;
            send_idx <= '0;
            addr     <= '0;
            wdata    <= '0;
`ifdef UART_BUS_MASTER_ACK_EN
            ack_byte <= 8'h06;
`endif
        end else begin
            p_state <= p_next;
            if (p_state == P_IDLE && rx_valid && is_cmd) begin
                cmd_rd <= (rx_byte == CMD_RD);
                p_cnt  <= '0;
            end
            if (p_state == P_ADDR && rx_valid) begin
                addr  <= {addr[23:0], rx_byte};
                p_cnt <= p_cnt + 1'b1;
            end
            if (p_state == P_DATA && rx_valid) begin
                wdata <= {wdata[23:0], rx_byte};
                p_cnt <= p_cnt + 1'b1;
            end
            if ((p_state == P_ADDR || p_state == P_DATA) && !rx_valid)
                tmo_cnt <= tmo_cnt + 1'b1;
            else
                tmo_cnt <= '0;
            if (p_state == P_RD) rd_word <= rdata;
            if (p_next != p_state) send_idx <= '0;
            else if (tx_start)     send_idx <= send_idx + 1'b1;
`ifdef UART_BUS_MASTER_ACK_EN
            if (p_next == P_ACK && p_state != P_ACK)
                ack_byte <= (p_state == P_WR) ? 8'h06 : 8'h15;
`endif
        end
    end

    assign rd   = (p_state == P_RD);
    assign wr   = (p_state == P_WR);
    assign busy = (p_state != P_IDLE);

endmodule

// File: tb/tb_uart_bus_master.sv
// Directed bench for uart_bus_master: host-side UART driver, independent TX decoder and bus-event scoreboard.
`timescale 1ns/1ps
module tb_uart_bus_master;
    localparam int unsigned CPB = 8;
    localparam int unsigned TMO = 1000;
    // start-bit drive edge to wr/rd cycle: 9 bit periods to the stop bit, half a bit to its sample, sync + edge detect + 1
    localparam int unsigned LAT = 9 * CPB + CPB / 2 + 3;

    logic        CLK = 1'b0;
    logic        Reset_n = 1'b0;
    logic        rx_line = 1'b1;
    logic        out, rd, wr, busy;
    logic [31:0] addr, wdata, rdata;
    logic [31:0] cur_rdata = 32'h0;

    typedef struct {
        bit          is_rd;
        logic [31:0] a;
        logic [31:0] d;
        int unsigned cyc;
    } bus_ev_t;

    bus_ev_t     exp_bus[$];
    logic [7:0]  exp_tx[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int unsigned cyc = 0;
    bit          prev_strobe = 0;
    bit          rst_seen = 0;
    bus_ev_t     mon_ev;

    uart_bus_master #(.CLKS_PER_BIT(CPB), .TIMEOUT_CYC(TMO)) dut (
        .CLK(CLK), .Reset_n(Reset_n), .in(rx_line), .out(out),
        .rd(rd), .wr(wr), .addr(addr), .wdata(wdata), .rdata(rdata), .busy(busy)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;
    assign rdata = rd ? cur_rdata : 32'hA5A5_A5A5;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, expv);
        end
    endtask

    // bus scoreboard: every strobe must match the next expected transaction
    always @(negedge CLK) begin
        if (rd || wr) begin
            check("strobe_exclusive", {31'b0, rd & wr}, 32'd0);
            check("strobe_gap", {31'b0, prev_strobe}, 32'd0);
            if (exp_bus.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL bus_unexpected: rd=%b wr=%b addr=%h at cycle %0d", rd, wr, addr, cyc);
            end else begin
                mon_ev = exp_bus.pop_front();
                check("bus_kind_rd", {31'b0, rd}, {31'b0, mon_ev.is_rd});
                check("bus_addr", addr, mon_ev.a);
                if (!mon_ev.is_rd) check("bus_wdata", wdata, mon_ev.d);
                check("bus_cycle", cyc, mon_ev.cyc);
            end
        end
        prev_strobe = rd | wr;
    end

    always @(negedge Reset_n) rst_seen = 1;

    // host-side receiver on the TX line
    initial begin : tx_mon
        logic [7:0] b;
        logic       stop_bit;
        forever begin
            @(negedge CLK);
            if (Reset_n && out === 1'b0) begin
                rst_seen = 0;
                repeat (CPB / 2) @(negedge CLK);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge CLK);
                    b[i] = out;
                end
                repeat (CPB) @(negedge CLK);
                stop_bit = out;
                if (!rst_seen) begin
                    check("tx_stop_bit", {31'b0, stop_bit}, 32'd1);
                    if (exp_tx.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL tx_unexpected: got byte %h, none expected", b);
                    end else begin
                        check("tx_byte", {24'b0, b}, {24'b0, exp_tx.pop_front()});
                    end
                end
            end
        end
    end

    task automatic send_bit(input logic v);
        rx_line = v;
        repeat (CPB) @(posedge CLK);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
        if (!stop) send_bit(1'b1);
    endtask

    task automatic push_bus(input bit is_rd, input logic [31:0] a, input logic [31:0] d);
        bus_ev_t ev;
        ev.is_rd = is_rd;
        ev.a     = a;
        ev.d     = d;
        ev.cyc   = cyc + LAT;
        exp_bus.push_back(ev);
    endtask

    task automatic send_write_body(input logic [31:0] a, input logic [31:0] d);
        for (int i = 3; i >= 0; i--) send_byte(a[8*i +: 8], 1'b1);
        for (int i = 3; i >= 1; i--) send_byte(d[8*i +: 8], 1'b1);
        push_bus(1'b0, a, d);
        send_byte(d[7:0], 1'b1);
    endtask

    task automatic send_read(input logic [31:0] a, input logic [31:0] rv, input bit want_reply);
        cur_rdata = rv;
        if (want_reply) begin
            exp_tx.push_back(rv[31:24]);
            exp_tx.push_back(rv[23:16]);
            exp_tx.push_back(rv[15:8]);
            exp_tx.push_back(rv[7:0]);
        end
        send_byte(8'h52, 1'b1);
        for (int i = 3; i >= 1; i--) send_byte(a[8*i +: 8], 1'b1);
        push_bus(1'b1, a, 32'h0);
        send_byte(a[7:0], 1'b1);
    endtask

    task automatic wait_drain(input string name);
        int unsigned n = 0;
        while ((busy || exp_bus.size() != 0 || exp_tx.size() != 0) && n < 3000) begin
            @(posedge CLK);
            #1;
            n++;
        end
        repeat (2 * CPB) @(posedge CLK);
        #1;
        check({name, "_busy_idle"}, {31'b0, busy}, 32'd0);
        check({name, "_bus_pending"}, exp_bus.size(), 32'd0);
        check({name, "_tx_pending"}, exp_tx.size(), 32'd0);
        exp_bus.delete();
        exp_tx.delete();
    endtask

    initial begin
        #1;
        check("reset_out", {31'b0, out}, 32'd1);
        check("reset_rd", {31'b0, rd}, 32'd0);
        check("reset_wr", {31'b0, wr}, 32'd0);
        check("reset_addr", addr, 32'h0);
        check("reset_wdata", wdata, 32'h0);
        check("reset_busy", {31'b0, busy}, 32'd0);
        #20 Reset_n = 1'b1;
        repeat (4) @(posedge CLK);
        #1;

        // plain write
`ifdef UART_BUS_MASTER_ACK_EN
        exp_tx.push_back(8'h06);
`endif
        send_byte(8'h57, 1'b1);
        send_write_body(32'h4000_0018, 32'h0000_0041);
        wait_drain("write");
        check("write_addr_hold", addr, 32'h4000_0018);
        check("write_wdata_hold", wdata, 32'h0000_0041);

        // read with reply 00 00 00 1B
        send_read(32'h4000_0020, 32'h0000_001B, 1'b1);
        wait_drain("read");
        check("read_addr_hold", addr, 32'h4000_0020);

        // partial write frame abandoned by timeout
        send_byte(8'h57, 1'b1);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        check("timeout_partial_addr", addr, 32'h0020_1234);
        repeat (995) @(posedge CLK);
        #1;
        check("timeout_busy_before", {31'b0, busy}, 32'd1);
        repeat (5) @(posedge CLK);
        #1;
        check("timeout_busy_after", {31'b0, busy}, 32'd0);
        send_read(32'h0000_0004, 32'hCAFE_F00D, 1'b1);
        wait_drain("timeout_read");

        // framing error inside a write frame
`ifdef UART_BUS_MASTER_ACK_EN
        exp_tx.push_back(8'h15);
`endif
        send_byte(8'h57, 1'b1);
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b1);
        send_byte(8'hCC, 1'b0);
        wait_drain("ferr");

        // stray byte in idle, then a short start glitch inside the address field
        send_byte(8'h3F, 1'b1);
        check("stray_byte_busy", {31'b0, busy}, 32'd0);
`ifdef UART_BUS_MASTER_ACK_EN
        exp_tx.push_back(8'h06);
`endif
        send_byte(8'h57, 1'b1);
        rx_line = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        rx_line = 1'b1;
        repeat (2 * CPB) @(posedge CLK);
        #1;
        send_write_body(32'h0000_00F0, 32'h1234_5678);
        wait_drain("glitch_write");

        // reset while the read reply is on the wire
        send_read(32'h0000_0008, 32'h1122_3344, 1'b0);
        begin
            int unsigned n = 0;
            while (out !== 1'b0 && n < 200) begin
                @(posedge CLK);
                #1;
                n++;
            end
        end
        check("reply_started", {31'b0, out}, 32'd0);
        repeat (20) @(posedge CLK);
        #2 Reset_n = 1'b0;
        #1;
        check("midtx_reset_out", {31'b0, out}, 32'd1);
        check("midtx_reset_rd", {31'b0, rd}, 32'd0);
        check("midtx_reset_wr", {31'b0, wr}, 32'd0);
        check("midtx_reset_busy", {31'b0, busy}, 32'd0);
        check("midtx_reset_addr", addr, 32'h0);
        exp_tx.delete();
        repeat (3) @(posedge CLK);
        @(negedge CLK) Reset_n = 1'b1;
        repeat (2 * CPB) @(posedge CLK);
        #1;
        send_read(32'h0000_000C, 32'h0000_005A, 1'b1);
        wait_drain("post_reset_read");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
